// File: rtl/vga_sync_gen.sv
// 640x480@60 pixel-timing generator: counters, syncs, active video, write window, frame tick.
// Latency: flags are registered from next-state counters (zero skew); en=0 freezes all state.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int WIN_X     = 97,
    parameter int WIN_Y     = 206,
    parameter int WIN_W     = 448,
    parameter int WIN_H     = 70
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [9:0] counter1,
    output logic [9:0] counter2,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic       write,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] WX_LO    = 11'(WIN_X);
    localparam logic [10:0] WX_HI    = 11'(WIN_X + WIN_W);
    localparam logic [10:0] WY_LO    = 11'(WIN_Y);
    localparam logic [10:0] WY_HI    = 11'(WIN_Y + WIN_H);

    // Window predicate evaluated at the origin, used as the reset value of write.
    localparam logic WIN_AT_ORIGIN = (WIN_X == 0) && (WIN_W > 0) &&
                                     (WIN_Y == 0) && (WIN_H > 0);

    if (H_TOTAL > 1024) begin : g_h_total_chk
        $error("vga_sync_gen: H_TOTAL %0d does not fit the 10-bit counter", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
        $error("vga_sync_gen: V_TOTAL %0d does not fit the 10-bit counter", V_TOTAL);
    end
    if (WIN_X + WIN_W > H_VISIBLE) begin : g_win_x_chk
        $error("vga_sync_gen: write window exceeds visible width");
    end
    if (WIN_Y + WIN_H > V_VISIBLE) begin : g_win_y_chk
        $error("vga_sync_gen: write window exceeds visible height");
    end

    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] c1_nxt;
    logic [9:0] c2_nxt;
    logic       hs_nxt;
    logic       vs_nxt;
    logic       vis_nxt;
    logic       wr_nxt;
    logic       tick_nxt;
    logic [10:0] x_nxt;
    logic [10:0] y_nxt;

    // Flags are decoded from the values the counters are about to take, so the
    // registered flags always describe the pixel shown on the same cycle.
    always_comb begin
        h_wrap   = (counter2 == H_LAST);
        v_wrap   = (counter1 == V_LAST);
        c2_nxt   = counter2 + 10'd1;
        c1_nxt   = counter1;
        tick_nxt = 1'b0;
        if (h_wrap) begin
            c2_nxt = '0;
            if (v_wrap) begin
                c1_nxt   = '0;
                tick_nxt = 1'b1;
            end else begin
                c1_nxt = counter1 + 10'd1;
            end
        end
        x_nxt   = {1'b0, c2_nxt};
        y_nxt   = {1'b0, c1_nxt};
        hs_nxt  = !((x_nxt >= HS_START) && (x_nxt < HS_END));
        vs_nxt  = !((y_nxt >= VS_START) && (y_nxt < VS_END));
        vis_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        wr_nxt  = (x_nxt >= WX_LO) && (x_nxt < WX_HI) &&
                  (y_nxt >= WY_LO) && (y_nxt < WY_HI);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter1   <= '0;
            counter2   <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            visible    <= 1'b1;
            write      <= WIN_AT_ORIGIN;
            frame_tick <= 1'b0;
        end else if (en) begin
            counter1   <= c1_nxt;
            counter2   <= c2_nxt;
            hsync      <= hs_nxt;
            vsync      <= vs_nxt;
            visible    <= vis_nxt;
            write      <= wr_nxt;
            frame_tick <= tick_nxt;
        end else begin
            // Frozen: everything holds except the tick, which must not repeat.
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: vector table over one frame plus reset and enable-hold sequences.
// Vertical timing is shortened (27 lines) so a full frame is 21600 cycles.
module tb_vga_sync_gen;

    localparam int FRAME = 800 * 27;

    logic       clk;
    logic       reset;
    logic       en;
    logic [9:0] counter1;
    logic [9:0] counter2;
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic       write;
    logic       frame_tick;

    vga_sync_gen #(
        .V_VISIBLE(20),
        .V_FRONT  (2),
        .V_SYNC   (2),
        .V_BACK   (3),
        .WIN_Y    (6),
        .WIN_H    (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .counter1  (counter1),
        .counter2  (counter2),
        .hsync     (hsync),
        .vsync     (vsync),
        .visible   (visible),
        .write     (write),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        int   c1;
        int   c2;
        logic hs;
        logic vs;
        logic vis;
        logic wr;
        logic ft;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   idx;
    int   hs_lo, vs_lo, vis_hi, wr_hi, ft_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (at c1=%0d c2=%0d)",
                     name, act, exp, counter1, counter2);
        end
    endtask

    task automatic addv(input int cyc, input int c1, input int c2, input logic hs,
                        input logic vs, input logic vis, input logic wr, input logic ft);
        vec_t v;
        v.cyc = cyc; v.c1 = c1; v.c2 = c2;
        v.hs = hs; v.vs = vs; v.vis = vis; v.wr = wr; v.ft = ft;
        vecs.push_back(v);
    endtask

    task automatic check_state(input string tag, input int c1, input int c2, input logic hs,
                               input logic vs, input logic vis, input logic wr, input logic ft);
        check({tag, " counter1"}, 32'(counter1), 32'(c1));
        check({tag, " counter2"}, 32'(counter2), 32'(c2));
        check({tag, " hsync"}, 32'(hsync), 32'(hs));
        check({tag, " vsync"}, 32'(vsync), 32'(vs));
        check({tag, " visible"}, 32'(visible), 32'(vis));
        check({tag, " write"}, 32'(write), 32'(wr));
        check({tag, " frame_tick"}, 32'(frame_tick), 32'(ft));
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;

        //    cyc     c1  c2   hs vs vis wr ft   (cyc = line*800 + pixel)
        addv(0,      0,  0,   1, 1, 1, 0, 0);
        addv(96,     0,  96,  1, 1, 1, 0, 0);
        addv(97,     0,  97,  1, 1, 1, 0, 0);
        addv(639,    0,  639, 1, 1, 1, 0, 0);
        addv(640,    0,  640, 1, 1, 0, 0, 0);
        addv(655,    0,  655, 1, 1, 0, 0, 0);
        addv(656,    0,  656, 0, 1, 0, 0, 0);
        addv(751,    0,  751, 0, 1, 0, 0, 0);
        addv(752,    0,  752, 1, 1, 0, 0, 0);
        addv(799,    0,  799, 1, 1, 0, 0, 0);
        addv(800,    1,  0,   1, 1, 1, 0, 0);
        addv(4097,   5,  97,  1, 1, 1, 0, 0);
        addv(4896,   6,  96,  1, 1, 1, 0, 0);
        addv(4897,   6,  97,  1, 1, 1, 1, 0);
        addv(5344,   6,  544, 1, 1, 1, 1, 0);
        addv(5345,   6,  545, 1, 1, 1, 0, 0);
        addv(8544,   10, 544, 1, 1, 1, 1, 0);
        addv(8897,   11, 97,  1, 1, 1, 0, 0);
        addv(15839,  19, 639, 1, 1, 1, 0, 0);
        addv(16000,  20, 0,   1, 1, 0, 0, 0);
        addv(17599,  21, 799, 1, 1, 0, 0, 0);
        addv(17600,  22, 0,   1, 0, 0, 0, 0);
        addv(18256,  22, 656, 0, 0, 0, 0, 0);
        addv(19199,  23, 799, 1, 0, 0, 0, 0);
        addv(19200,  24, 0,   1, 1, 0, 0, 0);
        addv(21599,  26, 799, 1, 1, 0, 0, 0);
        addv(21600,  0,  0,   1, 1, 1, 0, 1);
        addv(21601,  0,  1,   1, 1, 1, 0, 0);

        repeat (3) @(negedge clk);
        reset = 1'b0;

        idx = 0;
        hs_lo = 0; vs_lo = 0; vis_hi = 0; wr_hi = 0; ft_cnt = 0;
        for (int n = 0; n <= FRAME + 1; n++) begin
            if (n > 0) @(negedge clk);
            if (n >= 1 && n <= FRAME) begin
                if (!hsync)    hs_lo++;
                if (!vsync)    vs_lo++;
                if (visible)   vis_hi++;
                if (write)     wr_hi++;
                if (frame_tick) ft_cnt++;
            end
            while (idx < vecs.size() && vecs[idx].cyc == n) begin
                check_state($sformatf("vec%0d", idx), vecs[idx].c1, vecs[idx].c2, vecs[idx].hs,
                            vecs[idx].vs, vecs[idx].vis, vecs[idx].wr, vecs[idx].ft);
                idx++;
            end
        end
        check("table_applied", 32'(idx), 32'(vecs.size()));
        check("hsync_low_cycles", 32'(hs_lo), 32'(96 * 27));
        check("vsync_low_cycles", 32'(vs_lo), 32'(1600));
        check("visible_cycles", 32'(vis_hi), 32'(640 * 20));
        check("write_cycles", 32'(wr_hi), 32'(448 * 5));
        check("frame_ticks", 32'(ft_cnt), 32'(1));

        // Asynchronous reset in the middle of a visible line.
        run(12399);
        check_state("pre_reset", 15, 400, 1, 1, 1, 0, 0);
        reset = 1'b1;
        #2;
        check_state("reset_async", 0, 0, 1, 1, 1, 0, 0);
        @(negedge clk);
        check_state("reset_held", 0, 0, 1, 1, 1, 0, 0);
        reset = 1'b0;

        // Freeze on the last pixel of the frame, then release into the wrap.
        run(FRAME - 1);
        check_state("last_pixel", 26, 799, 1, 1, 0, 0, 0);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_state($sformatf("hold%0d", k), 26, 799, 1, 1, 0, 0, 0);
        end
        en = 1'b1;
        @(negedge clk);
        check_state("wrap_after_hold", 0, 0, 1, 1, 1, 0, 1);

        // Freezing on (0,0) must not re-issue the tick.
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_state($sformatf("hold_origin%0d", k), 0, 0, 1, 1, 1, 0, 0);
        end
        en = 1'b1;
        @(negedge clk);
        check_state("resume_origin", 0, 1, 1, 1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
